// File: rtl/fusion_pkg.sv
// Shared types and constants for the fused bitbrick MAC.
// Precision encoding, brick geometry and FSM states.
package fusion_pkg;

   typedef enum logic [1:0] {
      PREC2,
      PREC4,
      PREC8,
      PREC_RSV
   } prec_e;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      PRESENT
   } state_e;

   localparam int BRICK_W  = 2;
   localparam int PROD_W   = 6;
   localparam int PIPE_LAT = 4;

   function automatic int lane_cnt(input int op_w, input prec_e p);
      unique case (p)
         PREC2:   return op_w / 2;
         PREC4:   return op_w / 4;
         PREC8:   return op_w / 8;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/bitbrick.sv
// 2x2-bit multiplier brick with per-operand sign control.
// Produces a 6-bit two's complement product.
module bitbrick (
   input  logic [1:0] x_i,
   input  logic [1:0] y_i,
   input  logic       sx_i,
   input  logic       sy_i,
   output logic [5:0] p_o
);

   logic [5:0] xw;
   logic [5:0] yw;
   logic [5:0] pr;

   assign xw  = {{4{sx_i & x_i[1]}}, x_i};
   assign yw  = {{4{sy_i & y_i[1]}}, y_i};
   assign pr  = xw * yw;
   assign p_o = pr;

endmodule

// File: rtl/bitbrick_array.sv
// Full cross-product of 2-bit slices of A and B, products registered (S2).
// Signed flags mark the top slice of each lane for the beat's precision.
module bitbrick_array
   import fusion_pkg::*;
#(
   parameter  int OP_W = 8,
   localparam int N    = OP_W / BRICK_W,
   localparam int PW   = N * N * PROD_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [OP_W-1:0] a_i,
   input  logic [OP_W-1:0] b_i,
   input  logic            sa_i,
   input  logic            sb_i,
   input  logic [1:0]      prec_i,
   output logic            valid_o,
   output logic [1:0]      prec_o,
   output logic [PW-1:0]   prod_o
);

   logic [N-1:0]  top;
   logic [PW-1:0] prod_d;
   logic [PW-1:0] prod_q;
   logic          valid_q;
   logic [1:0]    prec_q;

   always_comb begin
      top = '0;
      for (int i = 0; i < N; i++) begin
         unique case (prec_e'(prec_i))
            PREC2:   top[i] = 1'b1;
            PREC4:   top[i] = (i % 2) == 1;
            PREC8:   top[i] = (i % 4) == 3;
            default: top[i] = 1'b0;
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         bitbrick u_bb (
            .x_i  (a_i[i*BRICK_W +: BRICK_W]),
            .y_i  (b_i[j*BRICK_W +: BRICK_W]),
            .sx_i (sa_i & top[i]),
            .sy_i (sb_i & top[j]),
            .p_o  (prod_d[(i*N+j)*PROD_W +: PROD_W])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         prec_q  <= '0;
         prod_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            prec_q <= prec_i;
            prod_q <= prod_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign prec_o  = prec_q;
   assign prod_o  = prod_q;

endmodule

// File: rtl/fused_mac_unit.sv
// Run-time fused 2/4/8-bit dot-product MAC with flush-triggered result.
// FUSED_MAC_SAT_EN: saturate the accumulator instead of wrapping.
module fused_mac_unit
   import fusion_pkg::*;
#(
   parameter int OP_W  = 8,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic             sa,
   input  logic             sb,
   input  logic [1:0]       prec,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic             err
);

   localparam int N  = OP_W / BRICK_W;
   localparam int PW = N * N * PROD_W;
   localparam logic [1:0] CNT_LAST = 2'(PIPE_LAT - 2);
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              s1_v_q, sa_q, sb_q, err_q;
   logic [1:0]        prec_q;
   logic [OP_W-1:0]   a_q, b_q;
   logic              s2_v;
   logic [1:0]        s2_prec;
   logic [PW-1:0]     prod;
   logic              s3_v_q;
   logic [ACC_W-1:0]  dot_d, dot_q, term;
   logic [ACC_W-1:0]  acc_q, acc_d, sum;
   logic              ovf_q, ovf_d, add_ovf;
   logic [PROD_W-1:0] pp;
   logic              accept, flush_acc;

   assign in_ready  = (state_q == RUN);
   assign out_valid = (state_q == PRESENT);
   assign accept    = in_valid && in_ready;
   assign flush_acc = flush && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         prec_q <= '0;
         err_q  <= 1'b0;
      end else begin
         s1_v_q <= accept;
         err_q  <= err_q | (accept && prec == 2'd3);
         if (accept) begin
            a_q    <= a;
            b_q    <= b;
            sa_q   <= sa;
            sb_q   <= sb;
            prec_q <= prec;
         end
      end
   end

   bitbrick_array #(.OP_W(OP_W)) u_array (
      .clk     (clk),
      .reset   (reset),
      .valid_i (s1_v_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .sa_i    (sa_q),
      .sb_i    (sb_q),
      .prec_i  (prec_q),
      .valid_o (s2_v),
      .prec_o  (s2_prec),
      .prod_o  (prod)
   );

   // Only bricks whose A and B slices fall in the same lane contribute.
   always_comb begin
      dot_d = '0;
      term  = '0;
      pp    = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            pp   = prod[(i*N+j)*PROD_W +: PROD_W];
            term = {{(ACC_W-PROD_W){pp[PROD_W-1]}}, pp};
            unique case (prec_e'(s2_prec))
               PREC2: if (i == j)
                  dot_d = dot_d + term;
               PREC4: if (i / 2 == j / 2)
                  dot_d = dot_d + (term << (2 * (i % 2 + j % 2)));
               PREC8: if (i / 4 == j / 4)
                  dot_d = dot_d + (term << (2 * (i % 4 + j % 4)));
               default: ;
            endcase
         end
      end
   end

   assign sum     = acc_q + dot_q;
   assign add_ovf = (acc_q[ACC_W-1] == dot_q[ACC_W-1])
                 && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (s3_v_q) begin
         acc_d = sum;
         if (add_ovf) begin
            ovf_d = 1'b1;
`ifdef FUSED_MAC_SAT_EN
            acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
         end
      end
      if (state_q == PRESENT && out_ready) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         RUN: begin
            if (flush_acc) state_d = DRAIN;
         end
         DRAIN: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == CNT_LAST && !s1_v_q && !s2_v)
               state_d = PRESENT;
         end
         PRESENT: begin
            if (out_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s3_v_q  <= 1'b0;
         dot_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         s3_v_q  <= s2_v;
         if (s2_v) dot_q <= dot_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data = acc_q;
   assign out_ovf  = ovf_q;
   assign err      = err_q;

endmodule

// File: tb/tb_fused_mac_unit.sv
// Scoreboard bench for fused_mac_unit (OP_W=8, ACC_W=16).
// Directed beats; monitor checks each result as out_valid rises.
module tb_fused_mac_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        sa = 1'b0;
   logic        sb = 1'b0;
   logic [1:0]  prec = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_ovf;
   logic        err;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] data;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   logic ov_prev = 1'b0;

   fused_mac_unit #(.OP_W(8), .ACC_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sa        (sa),
      .sb        (sb),
      .prec      (prec),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (sbq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: got %0h, want none",
                        out_data);
            end else begin
               e = sbq.pop_front();
               chk("result_data", 32'(out_data), 32'(e.data));
               chk("result_ovf", 32'(out_ovf), 32'(e.ovf));
               chk("result_cycle", cyc, e.cyc);
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic drive(input logic v, input logic [7:0] av,
                        input logic [7:0] bv, input logic s_a,
                        input logic s_b, input logic [1:0] p,
                        input logic fl, input logic push,
                        input logic [15:0] ed, input logic eo);
      in_valid = v;
      a        = av;
      b        = bv;
      sa       = s_a;
      sb       = s_b;
      prec     = p;
      flush    = fl;
      if (fl && push) sbq.push_back('{ed, eo, cyc + 4});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      for (int k = 0; k < 40; k++) begin
         if (sbq.size() == 0 && in_ready && !out_valid) return;
         @(posedge clk);
         #1;
      end
      n_chk++;
      $display("FAIL %s_timeout: got pending=%0d, want 0", nm, sbq.size());
      sbq.delete();
   endtask

   task automatic wait_valid(input string nm);
      for (int k = 0; k < 12; k++) begin
         if (out_valid) return;
         @(posedge clk);
         #1;
      end
      n_chk++;
      $display("FAIL %s_timeout: got out_valid=0, want 1", nm);
   endtask

   initial begin
      int hits;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // 8-bit signed: four beats of -3*5
      for (int k = 0; k < 4; k++)
         drive(1, 8'hFD, 8'h05, 1, 1, 2'd2, k == 3, 1, 16'hFFC4, 0);
      wait_done("p8");

      // 2-bit unsigned: 4 lanes of 3*3
      drive(1, 8'hFF, 8'hFF, 0, 0, 2'd0, 1, 1, 16'd36, 0);
      wait_done("p2");

      // 4-bit signed: (-1*2) + (-8*2)
      drive(1, 8'h8F, 8'h22, 1, 1, 2'd1, 1, 1, 16'hFFEE, 0);
      wait_done("p4");

      // Back-pressure on the result
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         drive(1, 8'hFD, 8'h05, 1, 1, 2'd2, k == 3, 1, 16'hFFC4, 0);
      wait_valid("stall");
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'hFFC4);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      drive(0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 1, 16'd0, 0);
      wait_done("empty");

      // Reserved precision contributes nothing but flags err
      drive(1, 8'h55, 8'h55, 0, 0, 2'd3, 0, 0, 16'd0, 0);
      drive(1, 8'h02, 8'h03, 1, 1, 2'd2, 1, 1, 16'd6, 0);
      wait_done("rsv");
      chk("err_set", 32'(err), 32'd1);
      drive(0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 1, 16'd0, 0);
      wait_done("rsv_empty");
      chk("err_sticky", 32'(err), 32'd1);

      // Reset while draining discards the pending result
      drive(1, 8'h02, 8'h03, 1, 1, 2'd2, 1, 0, 16'd0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) hits++;
         @(posedge clk);
         #1;
      end
      chk("rst_drain_no_valid", hits, 0);
      chk("rst_drain_acc", 32'(out_data), 32'd0);
      chk("rst_drain_err", 32'(err), 32'd0);
      chk("rst_drain_in_ready", 32'(in_ready), 32'd1);
      drive(0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 1, 16'd0, 0);
      wait_done("rst_empty");

      // Two beats of (-128)*(-128) overflow a 16-bit accumulator
      drive(1, 8'h80, 8'h80, 1, 1, 2'd2, 0, 0, 16'd0, 0);
`ifdef FUSED_MAC_SAT_EN
      drive(1, 8'h80, 8'h80, 1, 1, 2'd2, 1, 1, 16'h7FFF, 1);
`else
      drive(1, 8'h80, 8'h80, 1, 1, 2'd2, 1, 1, 16'h8000, 1);
`endif
      wait_done("ovf");
      chk("ovf_cleared", 32'(out_ovf), 32'd0);
      drive(0, 8'h00, 8'h00, 0, 0, 2'd0, 1, 1, 16'd0, 0);
      wait_done("ovf_empty");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
